// File: rtl/flag_reg_stack.sv
// Condition-flag register with per-bit write mask, sticky OR-accumulate mode
// and a LIFO shadow stack for save/restore/swap around calls and interrupts.
module flag_reg_stack #(
  parameter int unsigned          WIDTH     = 3,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic [WIDTH-1:0]           wr_mask,
  input  logic                       sticky,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_nxt,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_q;
  logic [DW-1:0]    r_depth;
  logic             r_err;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_wr;
  logic [WIDTH-1:0] w_top;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_q_nxt;
  logic [DW-1:0]    w_depth_nxt;
  logic             w_err_set;
  logic             w_st_we;
  logic [AW-1:0]    w_st_idx;

  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_top_idx  = AW'(r_depth - DW'(1));
  assign w_push_idx = AW'(r_depth);
  assign w_top      = r_stack[w_top_idx];
  assign w_wr       = (r_q & ~wr_mask) | (wr_mask & (sticky ? (r_q | d) : d));

  // Stack writes only ever take the pre-edge q: a push saves it at the new
  // slot, a swap drops it into the current top slot.
  always_comb begin
    w_q_nxt     = w_wr;
    w_depth_nxt = r_depth;
    w_err_set   = 1'b0;
    w_st_we     = 1'b0;
    w_st_idx    = w_push_idx;
    if (rst) begin
      w_q_nxt     = RESET_VAL;
      w_depth_nxt = '0;
    end else if (clr) begin
      w_q_nxt = RESET_VAL;
      if (push) begin
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_st_we     = 1'b1;
          w_depth_nxt = r_depth + DW'(1);
        end
      end
    end else if (push && pop) begin
      if (w_empty) begin
        w_err_set = 1'b1;
        w_q_nxt   = r_q;
      end else begin
        w_q_nxt  = w_top;
        w_st_we  = 1'b1;
        w_st_idx = w_top_idx;
      end
    end else if (pop) begin
      if (w_empty) begin
        w_err_set = 1'b1;
      end else begin
        w_q_nxt     = w_top;
        w_depth_nxt = r_depth - DW'(1);
      end
    end else if (push) begin
      if (w_full) begin
        w_err_set = 1'b1;
      end else begin
        w_st_we     = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= RESET_VAL;
      r_depth <= '0;
      r_err   <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_depth <= w_depth_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_st_we) r_stack[w_st_idx] <= r_q;
  end

  assign q     = r_q;
  assign q_nxt = w_q_nxt;
  assign depth = r_depth;
  assign full  = w_full;
  assign empty = w_empty;
  assign err   = r_err;

endmodule

// File: tb/tb_flag_reg_stack.sv
// Scoreboard bench for flag_reg_stack: a queue-based reference model predicts
// each cycle's outcome; a separate monitor compares DUT outputs against it.
module tb_flag_reg_stack;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [WIDTH-1:0] wr_mask = '0;
  logic             sticky = 1'b0;
  logic             clr = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             err;

  flag_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
    .clk(clk), .rst(rst), .d(d), .wr_mask(wr_mask), .sticky(sticky),
    .clr(clr), .push(push), .pop(pop), .q(q), .q_nxt(q_nxt),
    .depth(depth), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    int unsigned      depth;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_stk[$];
  logic             m_err;
  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;

  // Reference model: spec rules applied to a plain queue, one call per cycle.
  task automatic step(input logic r, input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] mm,
                      input logic st, input logic cl, input logic pu, input logic po);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] tmp;
    exp_t e;
    rst = r; d = dd; wr_mask = mm; sticky = st; clr = cl; push = pu; pop = po;
    w = m_q;
    for (int i = 0; i < WIDTH; i++)
      if (mm[i]) w[i] = st ? (m_q[i] | dd[i]) : dd[i];
    if (r) begin
      m_q = '0; m_stk.delete(); m_err = 1'b0;
    end else if (cl) begin
      if (pu) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(m_q);
      end
      m_q = '0;
    end else if (pu && po) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else begin
        tmp = m_stk.pop_back();
        m_stk.push_back(m_q);
        m_q = tmp;
      end
    end else if (po) begin
      if (m_stk.size() == 0) begin
        m_err = 1'b1;
        m_q = w;
      end else m_q = m_stk.pop_back();
    end else if (pu) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back(m_q);
      m_q = w;
    end else begin
      m_q = w;
    end
    e.q = m_q; e.depth = m_stk.size(); e.err = m_err;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic wr(input logic [WIDTH-1:0] dd);
    step(1'b0, dd, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: q_nxt sampled mid-cycle, registered outputs just after the edge.
  logic [WIDTH-1:0] cap_qnxt;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3 cap_qnxt = q_nxt;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (cap_qnxt !== e.q) begin
          n_err++; $display("FAIL q_nxt vec %0d: got %b expected %b", n_vec, cap_qnxt, e.q);
        end
        if (q !== e.q) begin
          n_err++; $display("FAIL q vec %0d: got %b expected %b", n_vec, q, e.q);
        end
        if (depth !== DW'(e.depth)) begin
          n_err++; $display("FAIL depth vec %0d: got %0d expected %0d", n_vec, depth, e.depth);
        end
        if (full !== (e.depth == DEPTH)) begin
          n_err++; $display("FAIL full vec %0d: got %b expected %b", n_vec, full, e.depth == DEPTH);
        end
        if (empty !== (e.depth == 0)) begin
          n_err++; $display("FAIL empty vec %0d: got %b expected %b", n_vec, empty, e.depth == 0);
        end
        if (err !== e.err) begin
          n_err++; $display("FAIL err vec %0d: got %b expected %b", n_vec, err, e.err);
        end
      end
    end
  end

  initial begin
    int unsigned budget;
    m_q = '0; m_err = 1'b0;
    @(negedge clk);
    // masked overwrite
    step(1, 0, 0, 0, 0, 0, 0);
    wr(3'b101);
    step(0, 3'b000, 3'b010, 0, 0, 0, 0);
    step(0, 3'b000, 3'b001, 0, 0, 0, 0);
    // sticky vs overwrite
    wr(3'b001);
    step(0, 3'b100, 3'b111, 1, 0, 0, 0);
    step(0, 3'b100, 3'b111, 0, 0, 0, 0);
    // push with write, then pop
    wr(3'b011);
    step(0, 3'b100, 3'b111, 0, 0, 1, 0);
    step(0, 3'b000, 3'b000, 0, 0, 0, 1);
    // fill, overflow, drain, underflow
    wr(3'd1);
    step(0, 3'd2, 3'b111, 0, 0, 1, 0);
    step(0, 3'd3, 3'b111, 0, 0, 1, 0);
    step(0, 3'd4, 3'b111, 0, 0, 1, 0);
    step(0, 3'd0, 3'b000, 0, 0, 1, 0);
    step(0, 3'd7, 3'b111, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 3'd0, 3'b000, 0, 0, 0, 1);
    // swap non-empty then empty
    step(1, 0, 0, 0, 0, 0, 0);
    wr(3'b110);
    step(0, 3'b001, 3'b111, 0, 0, 1, 0);
    step(0, 3'b000, 3'b111, 0, 0, 1, 1);
    step(0, 3'b000, 3'b000, 0, 0, 0, 1);
    step(0, 3'b000, 3'b000, 0, 0, 0, 1);
    step(0, 3'b011, 3'b111, 0, 0, 1, 1);
    // clr with push, then reset mid-sequence
    wr(3'b111);
    step(0, 3'b010, 3'b111, 0, 1, 1, 0);
    step(0, 3'b000, 3'b000, 0, 0, 0, 1);
    step(0, 3'b000, 3'b000, 0, 0, 0, 1);
    step(1, 3'b111, 3'b111, 1, 1, 1, 1);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0),
           WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flag_reg_stack.md
Name: flag_reg_stack

Overview:
Parametrised condition-flag register with per-bit write masking, a sticky (OR-accumulate) write mode and a LIFO shadow stack of saved flag words. It is the successor to the plain 3-bit flag register used by the ALU/branch stage. Flags are saved and restored around subroutine or interrupt entry and exit, and can be swapped in a single cycle. At WIDTH=3 the bit order is [2]=Z, [1]=V, [0]=N.

Parameters:
WIDTH, 3, number of flag bits
DEPTH, 4, shadow stack entries (>=1)
RESET_VAL, 0 (WIDTH bits), value loaded into q on rst and on clr

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
d  in  WIDTH  new flag values
wr_mask  in  WIDTH  per-bit write enable; 0 means no write
sticky  in  1  1: masked bits are OR-ed into q (q|d); 0: masked bits are overwritten with d
clr  in  1  load RESET_VAL into q; stack untouched
push  in  1  save current q onto stack
pop  in  1  restore q from top of stack
q  out  WIDTH  registered flag value
q_nxt  out  WIDTH  combinational value q will take at the next edge (bypass to the branch unit)
depth  out  $clog2(DEPTH+1)  number of valid stack entries
full  out  1  depth==DEPTH
empty  out  1  depth==0
err  out  1  sticky error: set on an illegal push or pop; cleared only by rst

Behaviour:
- Reset (rst=1 at the edge): q=RESET_VAL, depth=0, err=0. Stack contents are don't-care. All other inputs are ignored that cycle. rst overrides everything.
- Masked write: for each bit i with wr_mask[i]=1, w[i] = sticky ? (q[i]|d[i]) : d[i]. Bits with wr_mask[i]=0 keep q[i]. wr_mask=0 is a no-op.
- Per-cycle priority when rst=0, evaluated from the pre-edge q and stack:
  1. clr=1: q_nxt=RESET_VAL. Writes and pop are ignored. A push in the same cycle still saves the old q, subject to the full check.
  2. push=1 and pop=1 (swap):
     - If non-empty: q_nxt=top entry, top entry receives old q, depth unchanged, write ignored.
     - If empty: no change to q or stack, err<=1, write ignored.
  3. pop=1 only:
     - If non-empty: q_nxt=top entry, depth-1, write ignored.
     - If empty: err<=1, depth stays 0, masked write applies normally.
  4. push=1 only:
     - If not full: stack[depth]<=old q, depth+1, and the masked write applies to q in the same cycle (the saved value is the pre-write q).
     - If full: err<=1, stack and depth unchanged, masked write applies.
  5. Otherwise: masked write only.
- Latency: one cycle from inputs to q. q_nxt is valid combinationally in the same cycle and equals the value q takes at the next edge.
- full and empty are combinational decodes of the depth register. No wrap-around: overflow and underflow never corrupt entries or depth.
- err is sticky and never self-clears.

Test Plan:
1. Reset, then wr_mask=3'b111, d=3'b101, sticky=0 -> q_nxt=3'b101 same cycle, q=3'b101 next cycle. Then wr_mask=3'b010, d=3'b000 -> q stays 3'b101. Then wr_mask=3'b001, d=3'b000 -> q=3'b100.
2. Sticky mode: q=3'b001, sticky=1, wr_mask=3'b111, d=3'b100 -> q=3'b101. Then sticky=0, same d -> q=3'b100.
3. Push with simultaneous write: q=3'b011, push=1, wr_mask=3'b111, d=3'b100 -> q=3'b100, depth=1. Then pop=1 alone -> q=3'b011, depth=0, empty=1.
4. Fill stack: push values 1,2,3,4 (DEPTH=4) -> full=1, depth=4. A fifth push -> err=1, depth=4. Pop four times -> q=4,3,2,1 in order, empty=1. A further pop -> err stays 1, q unchanged.
5. Swap: depth=1 with top=3'b110, q=3'b001, push=pop=1 -> q=3'b110, top=3'b001, depth=1. Swap when empty -> err=1, q unchanged.
6. clr with push at q=3'b111 -> q=RESET_VAL, stack top=3'b111, depth=1. Then rst mid-sequence -> q=0, depth=0, err=0, empty=1.
